// File: rtl/gate_response_checker_if.sv
// Bundles the self-test port signals of gate_response_checker.
// Ports: start/resp come from the test environment; stim/busy/done/pass,
//        err_count, first_fail_vec/vld and signature go back to it.
interface gate_response_checker_if;
  logic        start;
  logic [3:0]  stim;
  logic [6:0]  resp;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  err_count;
  logic [3:0]  first_fail_vec;
  logic        first_fail_vld;
  logic [15:0] signature;

  // master: the environment (requests runs, returns the block's response)
  modport master (
    output start, resp,
    input  stim, busy, done, pass, err_count, first_fail_vec, first_fail_vld, signature
  );

  // slave: the checker itself
  modport slave (
    input  start, resp,
    output stim, busy, done, pass, err_count, first_fail_vec, first_fail_vld, signature
  );
endinterface

// File: rtl/gate_response_checker.sv
// Self-test checker: sweeps {a,b,c,d} = 0..15 into the gate block, compares each
//   settled response to a golden model under a don't-care mask, counts failures,
//   and folds the masked responses into a 16-bit MISR signature.
// Latency: done rises 16*(SETTLE_CYCLES+1) edges after the start-accept edge.
// Backpressure: none; start is honoured only in IDLE/DONE and ignored while busy.
// Ports: clk, rst_n (async active-low), bus (slave modport: start, resp in;
//   stim, busy, done, pass, err_count, first_fail_vec/vld, signature out).
module gate_response_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,       // 1..15
  parameter logic [15:0] MISR_POLY     = 16'h1021,
  parameter logic [15:0] MISR_SEED     = 16'hFFFF
) (
  input logic                    clk,
  input logic                    rst_n,
  gate_response_checker_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // settle_cnt value on the last DRIVE cycle of a vector
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  vec;
  logic [3:0]  settle_cnt;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  err_count;
  logic [3:0]  first_fail_vec;
  logic        first_fail_vld;
  logic [15:0] signature;

  // Golden response and compare mask for the vector currently driven
  logic       a, b, c, d;
  logic [6:0] exp_resp;
  logic [6:0] mask;
  logic [6:0] masked_resp;
  logic       fail;
  logic [4:0] err_next;
  logic [15:0] sig_next;

  assign {a, b, c, d} = vec;

  always_comb begin
    exp_resp    = {a, a, a, (a | b | c), (c ^ d), (b | c), (a & b)};
    mask        = 7'h7F;
    // bit3 has two drivers that fight when a=c=0 and b!=d: value undefined
    if (!a && !c && (b != d)) mask[3] = 1'b0;
    // bit6 is tri-stated when d=0
    if (!d)                   mask[6] = 1'b0;
    masked_resp = bus.resp & mask;
    fail        = |((bus.resp ^ exp_resp) & mask);
    err_next    = err_count + {4'd0, fail};
    // Masked-off bits are zeroed before compaction so the signature is
    // independent of don't-care values.
    sig_next    = {signature[14:0], 1'b0}
                ^ (signature[15] ? MISR_POLY : 16'h0000)
                ^ {9'd0, masked_resp};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      vec            <= 4'd0;
      settle_cnt     <= 4'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 5'd0;
      first_fail_vec <= 4'd0;
      first_fail_vld <= 1'b0;
      signature      <= MISR_SEED;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state          <= ST_DRIVE;
            vec            <= 4'd0;
            settle_cnt     <= 4'd0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 5'd0;
            first_fail_vec <= 4'd0;
            first_fail_vld <= 1'b0;
            signature      <= MISR_SEED;
          end
        end

        ST_DRIVE: begin
          settle_cnt <= settle_cnt + 4'd1;
          if (settle_cnt == SETTLE_LAST) state <= ST_SAMPLE;
        end

        ST_SAMPLE: begin
          err_count <= err_next;
          signature <= sig_next;
          if (fail && !first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_vec <= vec;
          end
          if (vec == 4'd15) begin
            // vec stays at 15 so stim holds the last vector in DONE
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 5'd0);
          end else begin
            vec        <= vec + 4'd1;
            settle_cnt <= 4'd0;
            state      <= ST_DRIVE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // stim is the vector register itself, so it is 0 after reset/start and
  // walks 0..15 exactly with vec.
  assign bus.stim           = vec;
  assign bus.busy           = busy;
  assign bus.done           = done;
  assign bus.pass           = pass;
  assign bus.err_count      = err_count;
  assign bus.first_fail_vec = first_fail_vec;
  assign bus.first_fail_vld = first_fail_vld;
  assign bus.signature      = signature;

endmodule

// File: tb/tb_gate_response_checker.sv
module tb_gate_response_checker;

  localparam int SETTLE = 2;
  localparam int RUN_LEN = 16 * (SETTLE + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;

  gate_response_checker_if bus();

  gate_response_checker #(
    .SETTLE_CYCLES(SETTLE),
    .MISR_POLY    (16'h1021),
    .MISR_SEED    (16'hFFFF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model (truth-table level) ----------------
  function automatic logic [6:0] ideal(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return {a, a, a, (a | b | c), (c ^ d), (b | c), (a & b)};
  endfunction

  function automatic logic [6:0] care(input logic [3:0] v);
    logic [6:0] m;
    m = 7'h7F;
    if (v[3] == 1'b0 && v[1] == 1'b0 && v[2] != v[0]) m[3] = 1'b0;
    if (v[0] == 1'b0) m[6] = 1'b0;
    return m;
  endfunction

  // Responder: a per-run table indexed by stim, with optional jitter on the
  // don't-care bits that changes every cycle.
  logic [6:0] resp_tbl [16];
  logic [6:0] jit_bits = 7'd0;
  logic       jitter = 1'b0;
  always @(negedge clk) jit_bits = 7'($urandom);
  assign bus.resp = resp_tbl[bus.stim] ^ (jitter ? (jit_bits & ~care(bus.stim)) : 7'd0);

  typedef struct {
    int          errs;
    logic        ffvld;
    logic [3:0]  ffv;
    logic [15:0] sig;
    int          done_edge;
  } exp_t;

  function automatic exp_t predict(input int start_edge);
    exp_t e;
    logic [15:0] s;
    logic [6:0]  m, r;
    s = 16'hFFFF;
    e.errs = 0; e.ffvld = 1'b0; e.ffv = 4'd0;
    for (int v = 0; v < 16; v++) begin
      m = care(4'(v));
      r = resp_tbl[v];
      if (((r ^ ideal(4'(v))) & m) != 7'd0) begin
        e.errs++;
        if (!e.ffvld) begin e.ffvld = 1'b1; e.ffv = 4'(v); end
      end
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {9'd0, r & m};
    end
    e.sig = s;
    e.done_edge = start_edge + RUN_LEN;
    return e;
  endfunction

  // mode 0 ideal, 1 resp[0] stuck-at-1, 2 ideal + don't-care jitter, 3 random faults
  task automatic fill(input int mode);
    for (int v = 0; v < 16; v++) begin
      case (mode)
        1:       resp_tbl[v] = ideal(4'(v)) | 7'd1;
        3:       resp_tbl[v] = ideal(4'(v)) ^ (($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'd0);
        default: resp_tbl[v] = ideal(4'(v));
      endcase
    end
    jitter = (mode == 2);
  endtask

  // ---------------- scoreboard / monitor ----------------
  exp_t        q[$];
  int          run_start = -1;
  int          stim_bad = 0;
  logic [15:0] last_sig = 16'h0;

  initial begin : monitor
    exp_t e;
    int   j;
    logic done_q;
    done_q = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (run_start >= 0 && bus.busy) begin
        j = cyc - run_start;
        if (bus.stim !== 4'(j / 3)) stim_bad++;
      end
      if (bus.done && !done_q) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("done_latency",   cyc,                 e.done_edge);
          chk("err_count",      bus.err_count,       e.errs);
          chk("pass",           bus.pass,            (e.errs == 0));
          chk("first_fail_vld", bus.first_fail_vld,  e.ffvld);
          chk("first_fail_vec", bus.first_fail_vec,  e.ffv);
          chk("signature",      bus.signature,       e.sig);
          chk("stim_hold_15",   bus.stim,            4'd15);
          chk("busy_in_done",   bus.busy,            1'b0);
          chk("stim_walk",      stim_bad,            0);
          last_sig = bus.signature;
        end
      end
      done_q = bus.done;
    end
  end

  // ---------------- driver ----------------
  task automatic start_run();
    exp_t e;
    @(negedge clk);
    run_start = -1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    stim_bad = 0;
    e = predict(cyc);
    q.push_back(e);
    run_start = cyc;
    chk("accept_busy",     bus.busy,           1'b1);
    chk("accept_done",     bus.done,           1'b0);
    chk("accept_pass",     bus.pass,           1'b0);
    chk("accept_err",      bus.err_count,      5'd0);
    chk("accept_ffvld",    bus.first_fail_vld, 1'b0);
    chk("accept_ffvec",    bus.first_fail_vec, 4'd0);
    chk("accept_sig",      bus.signature,      16'hFFFF);
    chk("accept_stim",     bus.stim,           4'd0);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!bus.done && t < RUN_LEN + 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stim"},  bus.stim,           4'd0);
    chk({tag, "_busy"},  bus.busy,           1'b0);
    chk({tag, "_done"},  bus.done,           1'b0);
    chk({tag, "_pass"},  bus.pass,           1'b0);
    chk({tag, "_err"},   bus.err_count,      5'd0);
    chk({tag, "_ffvec"}, bus.first_fail_vec, 4'd0);
    chk({tag, "_ffvld"}, bus.first_fail_vld, 1'b0);
    chk({tag, "_sig"},   bus.signature,      16'hFFFF);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [15:0] sig_ideal;
    int t;
    bus.start = 1'b0;
    fill(0);

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Ideal responder
    fill(0);
    start_run();
    wait_done();
    sig_ideal = last_sig;
    chk("ideal_pass", bus.pass, 1'b1);

    // resp[0] stuck at 1: 12 of 16 vectors have a&b=0
    fill(1);
    start_run();
    wait_done();
    chk("stuck_err_count", bus.err_count, 5'd12);
    chk("stuck_ffvec",     bus.first_fail_vec, 4'h0);

    // Don't-care bits jitter: result must match the ideal run exactly
    fill(2);
    start_run();
    wait_done();
    chk("masked_err_count", bus.err_count, 5'd0);
    chk("masked_sig_same",  last_sig, sig_ideal);

    // start while busy is ignored; start in DONE clears and restarts
    fill(1);
    start_run();
    repeat (10) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_spurious_start", bus.busy, 1'b1);
    wait_done();
    fill(0);
    start_run();
    wait_done();

    // Reset during vector 7, then a full run from vec 0
    fill(3);
    start_run();
    t = 0;
    while (bus.stim != 4'd7 && t < RUN_LEN) begin
      @(negedge clk);
      t++;
    end
    chk("reached_vec7", bus.stim, 4'd7);
    #2 rst_n = 1'b0;
    run_start = -1;
    q.delete();
    #1 chk_reset_vals("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    start_run();
    wait_done();

    // Randomised response tables
    repeat (6) begin
      fill(3);
      start_run();
      wait_done();
    end

    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
